// File: rtl/spike_threshold_detector.sv
`default_nettype none
// ============================================================================
// spike_threshold_detector: per-channel edge-triggered threshold detector with
// refractory period, feeding a first-word-fall-through spike event FIFO.
// Revision: 1.0
// ============================================================================
module spike_threshold_detector #(
  parameter int CHANNELS     = 5,
  parameter int CHANNELS_PW2 = 7,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_PW2     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             chan_in_sample,
  input  logic [CHANNELS_PW2-1:0] chan_in_num,
  input  logic                    chan_in_valid,
  output logic                    chan_in_read,
  input  logic [15:0]             threshold,
  input  logic                    polarity,
  input  logic [11:0]             refractory,
  input  logic [CHANNELS-1:0]     chan_enable,
  output logic [CHANNELS_PW2-1:0] event_chan_num,
  output logic [15:0]             event_sample,
  output logic                    event_valid,
  input  logic                    event_read,
  output logic                    overflow,
  input  logic                    overflow_clear
);

  localparam int                    EVT_W      = CHANNELS_PW2 + 16;
  localparam logic [CHANNELS_PW2-1:0] C_NUM_CH = CHANNELS_PW2'(CHANNELS);
  localparam logic [FIFO_PW2:0]     C_FULL     = (FIFO_PW2 + 1)'(FIFO_DEPTH);

  // Stage 1: capture the accepted sample and its in-zone result
  logic                    chan_in_read_q;
  logic                    s1_valid_q;
  logic [CHANNELS_PW2-1:0] s1_chan_q;
  logic [15:0]             s1_sample_q;
  logic                    s1_zone_q;
  logic                    w_accept;
  logic                    w_in_zone;

  assign w_accept     = chan_in_valid && chan_in_read_q;
  assign chan_in_read = chan_in_read_q;

  always_comb begin
    w_in_zone = 1'b0;
    if (polarity) begin
      w_in_zone = $signed(chan_in_sample) >= $signed(threshold);
    end else begin
      w_in_zone = $signed(chan_in_sample) <= $signed(threshold);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      chan_in_read_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_chan_q      <= '0;
      s1_sample_q    <= '0;
      s1_zone_q      <= 1'b0;
    end else begin
      chan_in_read_q <= 1'b1;
      s1_valid_q     <= w_accept && (chan_in_num < C_NUM_CH);
      if (w_accept) begin
        s1_chan_q   <= chan_in_num;
        s1_sample_q <= chan_in_sample;
        s1_zone_q   <= w_in_zone;
      end
    end
  end

  // Stage 2: per-channel state is read and written on the same edge, so a
  // following sample of the same channel always sees the updated values.
  logic [CHANNELS-1:0] w_fire;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic        zone_flag_q;
    logic [11:0] refr_cnt_q;
    logic        w_sel;

    assign w_sel     = s1_valid_q && (s1_chan_q == CHANNELS_PW2'(g));
    assign w_fire[g] = w_sel && s1_zone_q && !zone_flag_q &&
                       (refr_cnt_q == 12'd0) && chan_enable[g];

    always_ff @(posedge clk) begin
      if (!reset) begin
        zone_flag_q <= 1'b1;
        refr_cnt_q  <= 12'd0;
      end else if (w_sel) begin
        zone_flag_q <= s1_zone_q;
        if (w_fire[g]) begin
          refr_cnt_q <= refractory;
        end else if (refr_cnt_q != 12'd0) begin
          refr_cnt_q <= refr_cnt_q - 12'd1;
        end
      end
    end
  end

  // Event FIFO
  logic [EVT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_PW2-1:0] rd_ptr_q;
  logic [FIFO_PW2-1:0] wr_ptr_q;
  logic [FIFO_PW2:0]   count_q;
  logic [FIFO_PW2:0]   count_d;
  logic                overflow_q;
  logic                overflow_d;
  logic                w_push;
  logic                w_pop;
  logic                w_wr;
  logic                w_full;

  assign w_push      = |w_fire;
  assign w_full      = (count_q == C_FULL);
  assign event_valid = (count_q != '0);
  assign w_pop       = event_valid && event_read;
  assign w_wr        = w_push && (!w_full || w_pop);
  assign overflow    = overflow_q;

  always_comb begin
    count_d    = count_q;
    overflow_d = (overflow_q && !overflow_clear) || (w_push && !w_wr);
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      fifo_mem_q[wr_ptr_q] <= {s1_chan_q, s1_sample_q};
    end
  end

  always_comb begin
    event_chan_num = '0;
    event_sample   = '0;
    if (event_valid) begin
      {event_chan_num, event_sample} = fifo_mem_q[rd_ptr_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_threshold_detector.sv
`default_nettype none
// ============================================================================
// tb_spike_threshold_detector: directed stimulus, sample-level reference model
// and per-cycle output comparison for spike_threshold_detector.
// Revision: 1.0
// ============================================================================
module tb_spike_threshold_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] chan_in_sample;
  logic [6:0]  chan_in_num;
  logic        chan_in_valid;
  logic        chan_in_read;
  logic [15:0] threshold;
  logic        polarity;
  logic [11:0] refractory;
  logic [4:0]  chan_enable;
  logic [6:0]  event_chan_num;
  logic [15:0] event_sample;
  logic        event_valid;
  logic        event_read;
  logic        overflow;
  logic        overflow_clear;

  int total = 0;
  int bad   = 0;

  spike_threshold_detector #(
    .CHANNELS(5), .CHANNELS_PW2(7), .FIFO_DEPTH(8), .FIFO_PW2(3)
  ) dut (
    .clk(clk), .reset(reset),
    .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
    .chan_in_valid(chan_in_valid), .chan_in_read(chan_in_read),
    .threshold(threshold), .polarity(polarity), .refractory(refractory),
    .chan_enable(chan_enable),
    .event_chan_num(event_chan_num), .event_sample(event_sample),
    .event_valid(event_valid), .event_read(event_read),
    .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int s;
  } ev_t;

  // Reference model: sample-level rules, events appear one edge after the
  // model sees the sample (total of two edges from acceptance).
  ev_t mq[$];
  ev_t got[$];
  ev_t pend;
  bit  pend_v;
  bit  m_flag[5];
  int  m_refr[5];
  bit  m_ovf;
  bit  m_read;
  bit  m_drop;
  bit  m_zone;
  int  m_c;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", n, a, a, e, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_ovf  = 0;
      m_read = 0;
      pend_v = 0;
      for (int i = 0; i < 5; i++) begin
        m_flag[i] = 1;
        m_refr[i] = 0;
      end
    end else begin
      m_drop = 0;
      if (mq.size() > 0 && event_read) void'(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < 8) mq.push_back(pend);
        else m_drop = 1;
      end
      m_ovf  = (m_ovf && !overflow_clear) || m_drop;
      pend_v = 0;
      if (m_read && chan_in_valid && chan_in_num < 7'd5) begin
        m_c    = int'(chan_in_num);
        m_zone = polarity ? ($signed(chan_in_sample) >= $signed(threshold))
                          : ($signed(chan_in_sample) <= $signed(threshold));
        if (m_zone && !m_flag[m_c] && m_refr[m_c] == 0 && chan_enable[m_c]) begin
          pend_v      = 1;
          pend.ch     = m_c;
          pend.s      = int'($signed(chan_in_sample));
          m_refr[m_c] = int'(refractory);
        end else if (m_refr[m_c] > 0) begin
          m_refr[m_c]--;
        end
        m_flag[m_c] = m_zone;
      end
      m_read = 1;
    end
  end

  always @(negedge clk) begin
    chk("chan_in_read", {31'd0, chan_in_read}, {31'd0, m_read});
    chk("event_valid", {31'd0, event_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (mq.size() > 0) begin
      chk("head_chan", {25'd0, event_chan_num}, mq[0].ch);
      chk("head_sample", {{16{event_sample[15]}}, event_sample}, mq[0].s);
    end else begin
      chk("idle_chan", {25'd0, event_chan_num}, 32'd0);
      chk("idle_sample", {16'd0, event_sample}, 32'd0);
    end
    if (event_valid === 1'b1 && event_read === 1'b1) begin
      got.push_back('{ch: int'(event_chan_num), s: int'($signed(event_sample))});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int ch, input int s);
    chan_in_valid  = 1'b1;
    chan_in_num    = ch[6:0];
    chan_in_sample = s[15:0];
    @(posedge clk);
    #1;
    chan_in_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic check_ev(input string n, input int idx, input int ch, input int s);
    if (idx < got.size()) begin
      chk({n, "_chan"}, got[idx].ch, ch);
      chk({n, "_sample"}, got[idx].s, s);
    end else begin
      chk({n, "_missing"}, got.size(), idx + 1);
    end
  endtask

  initial begin
    reset          = 1'b0;
    chan_in_sample = '0;
    chan_in_num    = '0;
    chan_in_valid  = 1'b0;
    threshold      = -16'sd200;
    polarity       = 1'b0;
    refractory     = 12'd0;
    chan_enable    = 5'b11111;
    event_read     = 1'b1;
    overflow_clear = 1'b0;
    idle(2);
    chk("reset_read", {31'd0, chan_in_read}, 32'd0);
    chk("reset_valid", {31'd0, event_valid}, 32'd0);
    reset = 1'b1;
    idle(1);

    // Falling crossings on ch2, latency, no re-fire while staying in zone
    got.delete();
    send(2, 0);
    chan_in_valid = 1'b1; chan_in_num = 7'd2; chan_in_sample = -16'sd250;
    @(posedge clk); #1;
    chan_in_valid = 1'b0;
    chk("lat_edge1_valid", {31'd0, event_valid}, 32'd0);
    idle(1);
    chk("lat_edge2_valid", {31'd0, event_valid}, 32'd1);
    chk("lat_edge2_chan", {25'd0, event_chan_num}, 32'd2);
    chk("lat_edge2_sample", {16'd0, event_sample}, 32'h0000_FF06);
    send(2, -300); send(2, 0); send(2, -250);
    idle(3);
    chk("t1_count", got.size(), 2);
    check_ev("t1_ev0", 0, 2, -250);
    check_ev("t1_ev1", 1, 2, -250);

    // First sample after reset is already in zone: must leave first
    do_reset();
    got.delete();
    send(0, -500); send(0, 0); send(0, -500);
    idle(3);
    chk("t2_count", got.size(), 1);
    check_ev("t2_ev0", 0, 0, -500);

    // Refractory of 3 samples on ch1, ch3 interleaved at 0
    do_reset();
    got.delete();
    refractory = 12'd3;
    for (int k = 1; k <= 10; k++) begin
      send(1, (k % 2 == 0) ? -300 : 0);
      send(3, 0);
    end
    idle(3);
    chk("t3_count", got.size(), 3);
    for (int k = 0; k < 3; k++) check_ev("t3_ev", k, 1, -300);

    // Disabled channel, out-of-range channel, zone tracking while disabled
    refractory = 12'd0;
    do_reset();
    got.delete();
    chan_enable = 5'b11011;
    send(2, 0); send(4, 0); send(2, -300); send(6, -1000); send(4, -300);
    idle(3);
    chan_enable = 5'b11111;
    idle(1);
    send(2, -300);
    idle(2);
    send(2, 0); send(2, -301);
    idle(3);
    chk("t4_count", got.size(), 2);
    check_ev("t4_ev0", 0, 4, -300);
    check_ev("t4_ev1", 1, 2, -301);

    // Rising polarity with equality at the threshold
    do_reset();
    got.delete();
    polarity  = 1'b1;
    threshold = 16'sd100;
    idle(1);
    send(3, 0); send(3, 150); send(3, 100); send(3, 99); send(3, 100);
    idle(3);
    chk("t5_count", got.size(), 2);
    check_ev("t5_ev0", 0, 3, 150);
    check_ev("t5_ev1", 1, 3, 100);
    polarity  = 1'b0;
    threshold = -16'sd200;

    // Overflow: 9 crossings into an 8-deep FIFO, then clear and drain
    do_reset();
    got.delete();
    event_read = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(0, 0);
      send(0, -300 - k);
    end
    idle(2);
    chk("t6_ovf_set", {31'd0, overflow}, 32'd1);
    chk("t6_hold_valid", {31'd0, event_valid}, 32'd1);
    chk("t6_hold_sample", {16'd0, event_sample}, 32'h0000_FED4);
    overflow_clear = 1'b1;
    idle(1);
    overflow_clear = 1'b0;
    chk("t6_ovf_clr", {31'd0, overflow}, 32'd0);
    event_read = 1'b1;
    idle(10);
    chk("t6_count", got.size(), 8);
    for (int k = 0; k < 8; k++) check_ev("t6_ev", k, 0, -300 - k);
    chk("t6_drained", {31'd0, event_valid}, 32'd0);

    // Reset one cycle after an accepted crossing discards everything
    do_reset();
    got.delete();
    event_read = 1'b0;
    send(0, 0); send(0, -300);
    idle(2);
    send(0, 0); send(0, -400);
    reset = 1'b0;
    idle(1);
    chk("t7_valid", {31'd0, event_valid}, 32'd0);
    chk("t7_read", {31'd0, chan_in_read}, 32'd0);
    chk("t7_ovf", {31'd0, overflow}, 32'd0);
    chk("t7_chan", {25'd0, event_chan_num}, 32'd0);
    chk("t7_sample", {16'd0, event_sample}, 32'd0);
    reset      = 1'b1;
    event_read = 1'b1;
    idle(4);
    chk("t7_count", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
